// File: rtl/full_adder_1b.sv
// One-bit full adder with a combinational path and a registered path that
// can chain its own carry across clocks for LSB-first bit-serial addition.
module full_adder_1b #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             cin,
   input  logic             en,
   input  logic             serial,
   input  logic             clr,
   output logic             s,
   output logic             cout,
   output logic             s_q,
   output logic             cout_q,
   output logic             carry_q,
   output logic [CNT_W-1:0] bit_cnt
);

   logic             r_s;
   logic             r_cout;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic             w_ci_eff;
   logic             w_sum_eff;
   logic             w_maj_eff;

   // Unregistered outputs see only the external carry, never the stored one.
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

   assign w_ci_eff  = serial ? r_carry : cin;
   assign w_sum_eff = a ^ b ^ w_ci_eff;
   assign w_maj_eff = (a & b) | (a & w_ci_eff) | (b & w_ci_eff);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s     <= 1'b0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (clr) begin
         // Word start: drop the chained carry, keep the last result visible.
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (en) begin
         r_s     <= w_sum_eff;
         r_cout  <= w_maj_eff;
         r_carry <= w_maj_eff;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign s_q     = r_s;
   assign cout_q  = r_cout;
   assign carry_q = r_carry;
   assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_full_adder_1b.sv
// Bench for full_adder_1b: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_full_adder_1b;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             clk_run = 1'b0;
   logic             rst = 1'b1;
   logic             a = 1'b0, b = 1'b0, cin = 1'b0;
   logic             en = 1'b0, serial = 1'b0, clr = 1'b0;
   logic             s, cout, s_q, cout_q, carry_q;
   logic [CNT_W-1:0] bit_cnt;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   // Reference state: plain integers, word arithmetic modulo 2^CNT_W.
   int m_s = 0, m_cout = 0, m_carry = 0, m_cnt = 0;

   full_adder_1b #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
      .serial(serial), .clr(clr), .s(s), .cout(cout), .s_q(s_q),
      .cout_q(cout_q), .carry_q(carry_q), .bit_cnt(bit_cnt)
   );

   always #5 clk = clk_run ? ~clk : 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a bit-serial adder is just "sum of three bits, low bit out, high bit carried".
   always @(posedge clk) begin
      int ci, tot;
      ci  = serial ? m_carry : int'(cin);
      tot = int'(a) + int'(b) + ci;
      if (rst) begin
         m_s <= 0; m_cout <= 0; m_carry <= 0; m_cnt <= 0;
      end else if (clr) begin
         m_carry <= 0; m_cnt <= 0;
      end else if (en) begin
         m_s     <= tot % 2;
         m_cout  <= tot / 2;
         m_carry <= tot / 2;
         m_cnt   <= (m_cnt + 1) % (1 << CNT_W);
      end
   end

   always @(negedge clk) begin
      int tot;
      if (chk_on) begin
         tot = int'(a) + int'(b) + int'(cin);
         chk("cmp_s",       int'(s),       tot % 2);
         chk("cmp_cout",    int'(cout),    tot / 2);
         chk("cmp_s_q",     int'(s_q),     m_s);
         chk("cmp_cout_q",  int'(cout_q),  m_cout);
         chk("cmp_carry_q", int'(carry_q), m_carry);
         chk("cmp_bit_cnt", int'(bit_cnt), m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic regs(input string name, input int es, input int ec, input int ek, input int en_cnt);
      chk({name, "_s_q"},     int'(s_q),     es);
      chk({name, "_cout_q"},  int'(cout_q),  ec);
      chk({name, "_carry_q"}, int'(carry_q), ek);
      chk({name, "_bit_cnt"}, int'(bit_cnt), en_cnt);
      $display("%-10s s_q=%0d cout_q=%0d carry_q=%0d bit_cnt=%0d", name, s_q, cout_q, carry_q, bit_cnt);
   endtask

   initial begin
      logic [1:0] sweep_exp [8];
      logic [2:0] v;
      int         serial_sq [3];
      sweep_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
      serial_sq = '{0, 0, 1};

      // Combinational sweep with the clock stopped.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a, b, cin} = v;
         #10;
         chk("sweep_s",    int'(s),    int'(sweep_exp[i][1]));
         chk("sweep_cout", int'(cout), int'(sweep_exp[i][0]));
         $display("sweep abc=%b s=%0d cout=%0d", v, s, cout);
      end

      clk_run = 1'b1;
      rst = 1'b1; en = 1'b1; clr = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b0;
      tick();
      chk_on = 1'b1;
      regs("reset", 0, 0, 0, 0);

      // Parallel registered path.
      rst = 1'b0; clr = 1'b0; en = 1'b1; serial = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b1;
      tick();
      regs("parallel", 1, 1, 1, 1);

      // Hold with toggling inputs.
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         {a, b, cin, serial} = 4'($urandom);
         tick();
         regs("hold", 1, 1, 1, 1);
      end

      // Serial 3 + 1, LSB first; cin held at 0 so the stored carry must be used.
      clr = 1'b1; en = 1'b0;
      tick();
      regs("clr", 1, 1, 0, 0);
      clr = 1'b0; en = 1'b1; serial = 1'b1; cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = (i < 2);
         b = (i == 0);
         tick();
         chk("serial_s_q", int'(s_q), serial_sq[i]);
         $display("serial bit %0d s_q=%0d carry_q=%0d", i, s_q, carry_q);
      end
      chk("serial_carry", int'(carry_q), 0);
      chk("serial_cnt",   int'(bit_cnt), 3);

      // Reset in the middle of a word.
      clr = 1'b1;
      tick();
      clr = 1'b0; serial = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b0;
      tick();
      tick();
      regs("midword", 0, 1, 1, 2);
      rst = 1'b1;
      #1;
      chk("rst_s",    int'(s),    0);
      chk("rst_cout", int'(cout), 1);
      tick();
      regs("midrst", 0, 0, 0, 0);
      rst = 1'b0;

      // Counter wrap, then clr beating en.
      for (int i = 0; i < 255; i++) begin
         {a, b, cin} = 3'($urandom);
         tick();
      end
      chk("wrap_255", int'(bit_cnt), 255);
      a = 1'b1; b = 1'b1; cin = 1'b1;
      tick();
      regs("wrap", 1, 1, 1, 0);
      clr = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0;
      tick();
      regs("clr_en", 1, 1, 0, 0);
      clr = 1'b0;

      // Randomized traffic, checked by the model every cycle.
      for (int i = 0; i < 2000; i++) begin
         rst    = ($urandom_range(0, 31) == 0);
         clr    = ($urandom_range(0, 15) == 0);
         en     = ($urandom_range(0, 3) != 0);
         serial = ($urandom_range(0, 3) != 0);
         {a, b, cin} = 3'($urandom);
         tick();
      end

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
